nibble_serial_add_ctrl: RTL and testbench
=========================================

// Module: nibble_serial_add_ctrl
// PURPOSE
//  Sequencer that computes a WIDTH-bit add on one shared 4-bit ripple-carry slice.
//  Each cycle it feeds one nibble; the slice cout is registered into the next cin.
//  Operands are taken on a valid/ready input handshake. The result is held on a
//  valid/ready output handshake. The block sits between an operand source and a result sink.
// PARAMETERS
//  WIDTH     16   operand/result width; must be a multiple of 4 and >= 4 (elaboration $error otherwise)
//  NIBBLES   WIDTH/4  localparam: number of slice passes
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operand request
//  in_ready   out  1      block can accept operands
//  op_a       in   WIDTH  operand A
//  op_b       in   WIDTH  operand B
//  cin        in   1      carry into nibble 0
//  op_sub     in   1      subtract select (present only with NSA_SUB_EN)
//  out_valid  out  1      result available
//  out_ready  in   1      sink accepts result
//  sum        out  WIDTH  result
//  cout       out  1      carry out of top nibble
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high.
//  Reset: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, busy=0, nibble idx=0, carry reg=0.
//  FSM IDLE->RUN: in_valid&&in_ready. Latch op_a, op_b and cin into the carry reg; idx=0.
//  RUN: each cycle the slice adds a_q[4*idx+:4] + b_q[4*idx+:4] + carry.
//    The nibble result goes to sum_q[4*idx+:4], the slice cout to the carry reg, and idx increments.
//  RUN->DONE after pass idx==NIBBLES-1. cout=final carry. out_valid rises the cycle after the last pass.
//  Latency: accept edge to out_valid = NIBBLES+1 cycles (WIDTH=16: 5).
//  DONE: out_valid=1 and sum/cout are stable until out_valid&&out_ready. Then ->IDLE.
//  in_ready=1 only in IDLE. A new request is accepted no earlier than the cycle after the output handshake.
//  Operands change while busy: ignored, because operands are latched at accept.
//  sum/cout hold their last value in IDLE and are only updated at the RUN->DONE edge.
//  out_ready while not DONE: ignored. in_valid while busy: stalls (no loss, no accept).
//  Arithmetic: unsigned, modulo 2^WIDTH; {cout,sum} == op_a+op_b+cin exactly (WIDTH+1 bits).
//  Reset mid-RUN or mid-DONE: the operation is discarded and all outputs return to reset values immediately.
// CONFIGURATION
//  NSA_SUB_EN defined: op_sub port exists. When op_sub=1 at accept, B is latched as ~op_b
//    and the initial carry is forced to 1; cin is ignored. Result = op_a-op_b mod 2^WIDTH.
//    In that case cout=1 means no borrow.
//  NSA_SUB_EN undefined: no op_sub port; add only; the port list above minus op_sub.
// STRUCTURE
//  Package nsa_pkg: typedef enum logic [1:0] {IDLE,RUN,DONE} nsa_state_t; localparam NIBBLE_W=4.
//  Sub-module nibble_rca4: 4-bit combinational ripple-carry slice (a,b,cin -> s,cout).
//    It has one instance, built from full-adder bit cells.
//  Top: FSM, idx counter ($clog2(NIBBLES) bits, min 1), operand/sum/carry registers.
// TESTING  (WIDTH=16 unless noted)
//  1. a=0x000F,b=0x000D,cin=0 -> sum=0x001C,cout=0. out_valid 5 cycles after accept.
//     Run the same case with WIDTH=4: sum=0xC, cout=1.
//  2. a=0xFFFF,b=0x0001,cin=0 -> sum=0x0000,cout=1 (carry ripples through all 4 passes).
//  3. a=0x1234,b=0x4321,cin=1; out_ready held 0 for 10 cycles.
//     -> sum=0x5556 stable and out_valid=1 throughout, in_ready=0; in_valid pulses not accepted.
//  4. rst asserted during RUN pass 2 -> outputs zero at once, state IDLE.
//     A subsequent a=0x0001,b=0x0001 then gives sum=0x0002,cout=0.
//  5. Back-to-back: two requests with out_ready=1 -> second accepted exactly 1 cycle after the first output handshake.
//     Both results correct; 1000 random operands checked against {cout,sum}==a+b+cin.
//  6. NSA_SUB_EN, op_sub=1: a=0x0005,b=0x0007 -> sum=0xFFFE,cout=0.
//     a=0x0007,b=0x0005 -> sum=0x0002,cout=1.

Source files
------------

// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
// Optional feature macro used by this block: NSA_SUB_EN (subtract mode).
package nsa_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } nsa_state_t;

    localparam int NIBBLE_W = 4;

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Operand/result handshake bundle for the nibble-serial adder sequencer.
// The slave modport is the adder; the master modport is the operand source plus result sink.
// With NSA_SUB_EN defined the bundle also carries the op_sub select.
interface nibble_serial_add_ctrl_if #(
    parameter int WIDTH = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
`ifdef NSA_SUB_EN
    logic             op_sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

`ifdef NSA_SUB_EN
    modport master (
        output in_valid, op_a, op_b, cin, op_sub, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, cin, op_sub, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
`else
    modport master (
        output in_valid, op_a, op_b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
`endif

endinterface

// File: rtl/nibble_serial_add_ctrl_rca4.sv
// Purely combinational 4-bit ripple-carry slice built from full-adder bit cells.
// The sequencer reuses this single slice for every nibble of the operands.
module nibble_rca4
    import nsa_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    input  logic                cin_i,
    output logic [NIBBLE_W-1:0] s_o,
    output logic                cout_o
);

    logic [NIBBLE_W:0] carry;

    assign carry[0] = cin_i;

    // One full-adder cell per bit; each cell's carry feeds the next cell up.
    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        assign s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = carry[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder sequencer: one WIDTH-bit add spread over WIDTH/4 passes of a
// shared 4-bit ripple-carry slice, with the slice carry registered between passes.
// Operands arrive on a valid/ready handshake; the result is held on a valid/ready handshake.
// Optional feature macro: NSA_SUB_EN adds op_sub, which turns the operation into A - B.
module nibble_serial_add_ctrl
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic                     clk,
    input logic                     rst,
    nibble_serial_add_ctrl_if.slave bus
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    if (WIDTH < NIBBLE_W || (WIDTH % NIBBLE_W) != 0) begin : g_width_check
        $error("nibble_serial_add_ctrl: WIDTH (%0d) must be a multiple of 4 and >= 4", WIDTH);
    end

    nsa_state_t       state_q,     state_d;
    logic [IDX_W-1:0] idx_q,       idx_d;
    logic [WIDTH-1:0] a_q,         a_d;
    logic [WIDTH-1:0] b_q,         b_d;
    logic [WIDTH-1:0] acc_q,       acc_d;
    logic             carry_q,     carry_d;
    logic [WIDTH-1:0] sum_q,       sum_d;
    logic             cout_q,      cout_d;
    logic             out_valid_q, out_valid_d;

    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;
    logic [NIBBLE_W-1:0] nib_s;
    logic                nib_cout;

    assign nib_a = a_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];
    assign nib_b = b_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];

    nibble_rca4 u_slice (
        .a_i    (nib_a),
        .b_i    (nib_b),
        .cin_i  (carry_q),
        .s_o    (nib_s),
        .cout_o (nib_cout)
    );

    // State, counter and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state logic: latch at accept, one slice pass per RUN cycle, and hold the
    // published result in DONE until the sink takes it. The visible sum/cout only change
    // on the RUN->DONE edge, so partial nibbles collect in acc_q meanwhile.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        carry_d     = carry_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.op_a;
                    b_d     = bus.op_b;
                    carry_d = bus.cin;
`ifdef NSA_SUB_EN
                    if (bus.op_sub) begin
                        b_d     = ~bus.op_b;
                        carry_d = 1'b1;
                    end
`endif
                    idx_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                acc_d[NIBBLE_W*int'(idx_q) +: NIBBLE_W] = nib_s;
                carry_d = nib_cout;
                if (idx_q == LAST_IDX) begin
                    sum_d   = acc_d;
                    cout_d  = nib_cout;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end

            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl (WIDTH=16 plus a WIDTH=4 instance).
// Expected results come from a behavioural add model and flow through a scoreboard queue.
// Subtract cases are included when NSA_SUB_EN is defined.
module tb_nibble_serial_add_ctrl;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int   vecs = 0;
    int   errs = 0;
    exp_t expQ[$];

    nibble_serial_add_ctrl_if #(.WIDTH(16)) bus16 ();
    nibble_serial_add_ctrl_if #(.WIDTH(4))  bus4 ();

    nibble_serial_add_ctrl #(.WIDTH(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    nibble_serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Hard stop in case a handshake never completes.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 5 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vecs++;
        assert (obs === expv) else begin
            errs++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Present one request, wait for acceptance, and record the model's answer.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic c, input logic sub);
        int          n;
        logic [16:0] full;
        exp_t        e;
        n = 0;
        bus16.op_a = a;
        bus16.op_b = b;
        bus16.cin  = c;
`ifdef NSA_SUB_EN
        bus16.op_sub = sub;
`endif
        bus16.in_valid = 1'b1;
        while (bus16.in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            cmp("accept_timeout", 32'd0, 32'd1);
            bus16.in_valid = 1'b0;
            return;
        end
        if (sub) full = {1'b0, a} + {1'b0, ~b} + 17'd1;
        else     full = {1'b0, a} + {1'b0, b} + {16'd0, c};
        e.sum  = full[15:0];
        e.cout = full[16];
        expQ.push_back(e);
        @(negedge clk);
        bus16.in_valid = 1'b0;
    endtask

    // Wait for a result, compare it with the scoreboard head, then take it.
    task automatic checkOutput(input string tag, input int expLat);
        int   n;
        exp_t e;
        n = 0;
        while (bus16.out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            cmp({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        if (expLat > 0) cmp({tag, "_latency"}, 32'(n), 32'(expLat));
        if (expQ.size() == 0) begin
            cmp({tag, "_unexpected"}, 32'd0, 32'd1);
            return;
        end
        e = expQ.pop_front();
        cmp({tag, "_sum"},  32'(bus16.sum),  32'(e.sum));
        cmp({tag, "_cout"}, 32'(bus16.cout), 32'(e.cout));
        bus16.out_ready = 1'b1;
        @(negedge clk);
        bus16.out_ready = 1'b0;
        cmp({tag, "_ovalid_drop"}, 32'(bus16.out_valid), 32'd0);
    endtask

    initial begin
        int          n;
        exp_t        e;
        logic [4:0]  full4;
        logic [15:0] ra, rb;
        logic        rc;

        bus16.in_valid  = 1'b0;
        bus16.op_a      = '0;
        bus16.op_b      = '0;
        bus16.cin       = 1'b0;
        bus16.out_ready = 1'b0;
        bus4.in_valid   = 1'b0;
        bus4.op_a       = '0;
        bus4.op_b       = '0;
        bus4.cin        = 1'b0;
        bus4.out_ready  = 1'b0;
`ifdef NSA_SUB_EN
        bus16.op_sub = 1'b0;
        bus4.op_sub  = 1'b0;
`endif

        // Reset values.
        #2 rst = 1'b1;
        #1;
        cmp("rst_sum",       32'(bus16.sum),       32'd0);
        cmp("rst_cout",      32'(bus16.cout),      32'd0);
        cmp("rst_out_valid", 32'(bus16.out_valid), 32'd0);
        cmp("rst_in_ready",  32'(bus16.in_ready),  32'd1);
        cmp("rst_busy",      32'(bus16.busy),      32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Small add with latency check.
        applyStimulus(16'h000F, 16'h000D, 1'b0, 1'b0);
        checkOutput("add_small", 5);

        // Carry ripples through every pass.
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        checkOutput("ripple_all", 5);

        // Sink stalls for 10 cycles while the source keeps poking in_valid.
        applyStimulus(16'h1234, 16'h4321, 1'b1, 1'b0);
        n = 0;
        while (bus16.out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            cmp("stall_out_valid", 32'(bus16.out_valid), 32'd1);
            cmp("stall_sum",       32'(bus16.sum),       32'h5556);
            cmp("stall_in_ready",  32'(bus16.in_ready),  32'd0);
            bus16.in_valid = (i % 2 == 0);
            bus16.op_a     = 16'hAAAA;
            bus16.op_b     = 16'h5555;
            @(negedge clk);
        end
        bus16.in_valid = 1'b0;
        checkOutput("stall", 0);
        @(negedge clk);
        cmp("stall_no_accept", 32'(bus16.busy), 32'd0);

        // Reset in the middle of RUN (pass 2).
        applyStimulus(16'h00FF, 16'h0F0F, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        cmp("midrst_sum",       32'(bus16.sum),       32'd0);
        cmp("midrst_cout",      32'(bus16.cout),      32'd0);
        cmp("midrst_out_valid", 32'(bus16.out_valid), 32'd0);
        cmp("midrst_in_ready",  32'(bus16.in_ready),  32'd1);
        cmp("midrst_busy",      32'(bus16.busy),      32'd0);
        expQ.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0);
        checkOutput("after_rst", 5);

        // Back-to-back: second request waits exactly one cycle past the first handshake.
        applyStimulus(16'h0A0A, 16'h0505, 1'b1, 1'b0);
        bus16.op_a      = 16'h8001;
        bus16.op_b      = 16'h7FFF;
        bus16.cin       = 1'b0;
        bus16.in_valid  = 1'b1;
        bus16.out_ready = 1'b1;
        n = 0;
        while (bus16.out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        cmp("b2b_first_latency", 32'(n), 32'd5);
        cmp("b2b_in_ready_done", 32'(bus16.in_ready), 32'd0);
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            cmp("b2b_first_sum",  32'(bus16.sum),  32'(e.sum));
            cmp("b2b_first_cout", 32'(bus16.cout), 32'(e.cout));
        end
        @(negedge clk);
        cmp("b2b_gap_out_valid", 32'(bus16.out_valid), 32'd0);
        cmp("b2b_gap_in_ready",  32'(bus16.in_ready),  32'd1);
        e.sum  = 16'h0000;
        e.cout = 1'b1;
        expQ.push_back(e);
        @(negedge clk);
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b0;
        cmp("b2b_second_busy",     32'(bus16.busy),     32'd1);
        cmp("b2b_second_in_ready", 32'(bus16.in_ready), 32'd0);
        checkOutput("b2b_second", 5);

        // Random operands against the behavioural model.
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            rc = 1'($urandom_range(0, 1));
            applyStimulus(ra, rb, rc, 1'b0);
            checkOutput("rnd", 5);
        end

`ifdef NSA_SUB_EN
        // Subtract mode; cin is deliberately set to show it is ignored.
        applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b1);
        checkOutput("sub_borrow", 5);
        applyStimulus(16'h0007, 16'h0005, 1'b0, 1'b1);
        checkOutput("sub_noborrow", 5);
        bus16.op_sub = 1'b0;
`endif

        // Single-nibble instance: one pass, so out_valid follows accept by 2 cycles.
        bus4.op_a     = 4'hF;
        bus4.op_b     = 4'hD;
        bus4.cin      = 1'b0;
        bus4.in_valid = 1'b1;
        full4 = {1'b0, 4'hF} + {1'b0, 4'hD};
        n = 0;
        while (bus4.in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus4.in_valid = 1'b0;
        n = 0;
        while (bus4.out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        cmp("w4_latency", 32'(n), 32'd2);
        cmp("w4_sum",     32'(bus4.sum),  32'(full4[3:0]));
        cmp("w4_cout",    32'(bus4.cout), 32'(full4[4]));
        bus4.out_ready = 1'b1;
        @(negedge clk);
        bus4.out_ready = 1'b0;
        cmp("w4_ovalid_drop", 32'(bus4.out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
